// File: rtl/positadd_raw_pipe_pkg.sv
// posit_defines: default ES2 posit widths, serialized field-offset helpers and
// the default-width stage payload type shared by the raw posit adder.
package posit_defines;

    localparam int POSIT_SCALE_W_ES2 = 8;
    localparam int POSIT_FRAC_W_ES2  = 27;
    localparam int GUARD_W           = 3;

    // Serialized operand layout is {sgn, scale, fraction, inf, zero}, zero at bit 0.
    function automatic int raw_sgn_pos(input int scale_w, input int frac_w);
        return scale_w + frac_w + 2;
    endfunction

    function automatic int raw_scale_lsb(input int frac_w);
        return frac_w + 2;
    endfunction

    function automatic int raw_frac_lsb();
        return 2;
    endfunction

    function automatic int mant_width(input int frac_w, input int guard_w);
        return frac_w + guard_w + 1;
    endfunction

    function automatic int sum_width(input int scale_w, input int frac_w, input int guard_w);
        return scale_w + frac_w + guard_w + 4;
    endfunction

    typedef struct packed {
        logic                          sgn;
        logic [POSIT_SCALE_W_ES2-1:0]  scale;
        logic [POSIT_FRAC_W_ES2-1:0]   frac;
        logic                          inf;
        logic                          zero;
    } posit_raw_t;

    typedef struct packed {
        logic                          hi_sgn;
        logic                          lo_sgn;
        logic [POSIT_SCALE_W_ES2-1:0]  hi_scale;
        logic [POSIT_SCALE_W_ES2-1:0]  lo_scale;
        logic [POSIT_FRAC_W_ES2-1:0]   hi_frac;
        logic [POSIT_FRAC_W_ES2-1:0]   lo_frac;
        logic                          lo_zero;
        logic                          both_zero;
        logic                          inf;
    } s1_payload_t;

endpackage

// File: rtl/positadd_raw_pipe_normalize.sv
// positadd_normalize: combinational leading-one detect, shift and scale adjust
// of the raw add/sub mantissa (carry bit at the top).
module positadd_normalize #(
    parameter int SCALE_W = posit_defines::POSIT_SCALE_W_ES2,
    parameter int FRAC_W  = posit_defines::POSIT_FRAC_W_ES2,
    parameter int GUARD_W = posit_defines::GUARD_W
) (
    input  logic [FRAC_W+GUARD_W+1:0] i_sum,
    input  logic [SCALE_W-1:0]        i_scale,
    output logic [SCALE_W:0]          o_scale,
    output logic [FRAC_W+GUARD_W-1:0] o_frac,
    output logic                      o_drop
);
    import posit_defines::*;

    localparam int MW = mant_width(FRAC_W, GUARD_W);
    localparam int PW = $clog2(MW + 1);

    logic [PW-1:0]      w_p;
    logic [PW-1:0]      w_lsh;
    logic [MW-2:0]      w_shl;
    logic [SCALE_W:0]   w_scale_x;

    // Leading-one search below the carry, then either a 1-bit right shift or a left shift.
    always_comb begin
        w_p = {PW{1'b0}};
        for (int i = 0; i < MW; i++) begin
            if (i_sum[i]) begin
                w_p = PW'(i);
            end else begin
                w_p = w_p;
            end
        end
        w_lsh     = PW'(MW - 1) - w_p;
        // The leading one leaves the field after the shift, so only the bits below it matter.
        w_shl     = i_sum[MW-2:0] << w_lsh;
        w_scale_x = {i_scale[SCALE_W-1], i_scale};
        if (i_sum[MW]) begin
            o_scale = w_scale_x + {{SCALE_W{1'b0}}, 1'b1};
            o_frac  = i_sum[MW-1:1];
            o_drop  = i_sum[0];
        end else begin
            o_scale = w_scale_x - (SCALE_W+1)'(w_lsh);
            o_frac  = w_shl;
            o_drop  = 1'b0;
        end
    end

endmodule

// File: rtl/positadd_raw_pipe.sv
// positadd_raw_pipe: 4-stage stallable raw posit add/sub with sticky truncation.
// Optional tag sideband enabled by defining POSITADD_TAG_EN.
module positadd_raw_pipe #(
    parameter int SCALE_W = posit_defines::POSIT_SCALE_W_ES2,
    parameter int FRAC_W  = posit_defines::POSIT_FRAC_W_ES2,
    parameter int GUARD_W = posit_defines::GUARD_W,
    parameter int TAG_W   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_sub,
    input  logic [SCALE_W+FRAC_W+2:0]         in_a,
    input  logic [SCALE_W+FRAC_W+2:0]         in_b,
    input  logic [TAG_W-1:0]                  in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [SCALE_W+FRAC_W+GUARD_W+3:0] out_sum,
    output logic                              out_trunc,
    output logic [TAG_W-1:0]                  out_tag
);
    import posit_defines::*;

    localparam int MW    = mant_width(FRAC_W, GUARD_W);
    localparam int SGN_P = raw_sgn_pos(SCALE_W, FRAC_W);
    localparam int SCL_L = raw_scale_lsb(FRAC_W);
    localparam int FRC_L = raw_frac_lsb();
    localparam int OW    = sum_width(SCALE_W, FRAC_W, GUARD_W);

    logic                w_advance;
    logic                w_a_sgn, w_b_sgn, w_a_zero, w_b_zero, w_a_hi;
    logic [SCALE_W-1:0]  w_a_scale, w_b_scale;
    logic [FRAC_W-1:0]   w_a_frac, w_b_frac;
    logic                w_hi_sgn, w_lo_sgn, w_lo_zero;
    logic [SCALE_W-1:0]  w_hi_scale, w_lo_scale;
    logic [FRAC_W-1:0]   w_hi_frac, w_lo_frac;

    logic                r1_valid, r1_hi_sgn, r1_lo_sgn, r1_lo_zero, r1_both_zero, r1_inf;
    logic [SCALE_W-1:0]  r1_hi_scale, r1_lo_scale;
    logic [FRAC_W-1:0]   r1_hi_frac, r1_lo_frac;

    logic [SCALE_W:0]    w_d;
    logic [31:0]         w_sh;
    logic [MW-1:0]       w_hi_m, w_lo_m, w_lo_al;
    logic [2*MW-1:0]     w_lo_ext;
    logic                w_al_trunc;
    logic [MW:0]         w_sum;

    logic                r2_valid, r2_sgn, r2_trunc, r2_inf, r2_both_zero;
    logic [SCALE_W-1:0]  r2_scale;
    logic [MW:0]         r2_sum;

    logic [SCALE_W:0]    w_n_scale;
    logic [MW-2:0]       w_n_frac;
    logic                w_n_drop;
    logic [OW-1:0]       w_res;
    logic                w_res_trunc;

    logic                r3_valid, r3_trunc, r4_valid, r4_trunc;
    logic [OW-1:0]       r3_sum, r4_sum;

    assign w_advance = ~r4_valid | out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r4_valid;
    assign out_sum   = r4_sum;
    assign out_trunc = r4_trunc;

    // Operand unpack: zero flag clears the numeric fields, subtract flips b's sign.
    always_comb begin
        w_a_zero = in_a[0];
        w_b_zero = in_b[0];
        if (w_a_zero) begin
            w_a_sgn   = 1'b0;
            w_a_scale = {SCALE_W{1'b0}};
            w_a_frac  = {FRAC_W{1'b0}};
        end else begin
            w_a_sgn   = in_a[SGN_P];
            w_a_scale = in_a[SGN_P-1:SCL_L];
            w_a_frac  = in_a[SCL_L-1:FRC_L];
        end
        if (w_b_zero) begin
            w_b_sgn   = 1'b0;
            w_b_scale = {SCALE_W{1'b0}};
            w_b_frac  = {FRAC_W{1'b0}};
        end else begin
            w_b_sgn   = in_b[SGN_P] ^ in_sub;
            w_b_scale = in_b[SGN_P-1:SCL_L];
            w_b_frac  = in_b[SCL_L-1:FRC_L];
        end
    end

    // Magnitude swap: a zero operand always goes low, ties keep a high.
    always_comb begin
        w_a_hi = w_b_zero | (~w_a_zero & (($signed(w_a_scale) > $signed(w_b_scale)) |
                 ((w_a_scale == w_b_scale) & (w_a_frac >= w_b_frac))));
        if (w_a_hi) begin
            w_hi_sgn = w_a_sgn; w_hi_scale = w_a_scale; w_hi_frac = w_a_frac;
            w_lo_sgn = w_b_sgn; w_lo_scale = w_b_scale; w_lo_frac = w_b_frac;
            w_lo_zero = w_b_zero;
        end else begin
            w_hi_sgn = w_b_sgn; w_hi_scale = w_b_scale; w_hi_frac = w_b_frac;
            w_lo_sgn = w_a_sgn; w_lo_scale = w_a_scale; w_lo_frac = w_a_frac;
            w_lo_zero = w_a_zero;
        end
    end

    // Alignment of the low mantissa with sticky collection, then the add or subtract.
    always_comb begin
        w_d = {r1_hi_scale[SCALE_W-1], r1_hi_scale} - {r1_lo_scale[SCALE_W-1], r1_lo_scale};
        if (32'(w_d) >= 32'(MW)) begin
            w_sh = 32'(MW);
        end else begin
            w_sh = 32'(w_d);
        end
        w_hi_m = {1'b1, r1_hi_frac, {GUARD_W{1'b0}}};
        if (r1_lo_zero) begin
            w_lo_m = {MW{1'b0}};
        end else begin
            w_lo_m = {1'b1, r1_lo_frac, {GUARD_W{1'b0}}};
        end
        w_lo_ext   = {w_lo_m, {MW{1'b0}}} >> w_sh;
        w_lo_al    = w_lo_ext[2*MW-1:MW];
        w_al_trunc = |w_lo_ext[MW-1:0];
        if (r1_hi_sgn == r1_lo_sgn) begin
            w_sum = {1'b0, w_hi_m} + {1'b0, w_lo_al};
        end else begin
            w_sum = {1'b0, w_hi_m} - {1'b0, w_lo_al};
        end
    end

    positadd_normalize #(
        .SCALE_W (SCALE_W),
        .FRAC_W  (FRAC_W),
        .GUARD_W (GUARD_W)
    ) u_normalize (
        .i_sum   (r2_sum),
        .i_scale (r2_scale),
        .o_scale (w_n_scale),
        .o_frac  (w_n_frac),
        .o_drop  (w_n_drop)
    );

    // Special-case priority: infinity, then zero results, then the normalized sum.
    always_comb begin
        if (r2_inf) begin
            w_res       = {{(OW-2){1'b0}}, 2'b10};
            w_res_trunc = 1'b0;
        end else if (r2_both_zero || (r2_sum == {(MW+1){1'b0}})) begin
            w_res       = {{(OW-1){1'b0}}, 1'b1};
            w_res_trunc = 1'b0;
        end else begin
            w_res       = {r2_sgn, w_n_scale, w_n_frac, 2'b00};
            w_res_trunc = r2_trunc | w_n_drop;
        end
    end

    // Lock-step pipeline: every stage moves only when the output slot can take data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_valid <= 1'b0; r1_hi_sgn <= 1'b0; r1_lo_sgn <= 1'b0; r1_lo_zero <= 1'b0;
            r1_both_zero <= 1'b0; r1_inf <= 1'b0;
            r1_hi_scale <= {SCALE_W{1'b0}}; r1_lo_scale <= {SCALE_W{1'b0}};
            r1_hi_frac <= {FRAC_W{1'b0}}; r1_lo_frac <= {FRAC_W{1'b0}};
            r2_valid <= 1'b0; r2_sgn <= 1'b0; r2_trunc <= 1'b0; r2_inf <= 1'b0;
            r2_both_zero <= 1'b0; r2_scale <= {SCALE_W{1'b0}}; r2_sum <= {(MW+1){1'b0}};
            r3_valid <= 1'b0; r3_trunc <= 1'b0; r3_sum <= {OW{1'b0}};
            r4_valid <= 1'b0; r4_trunc <= 1'b0; r4_sum <= {OW{1'b0}};
        end else if (w_advance) begin
            r1_valid     <= in_valid;
            r1_hi_sgn    <= w_hi_sgn;
            r1_lo_sgn    <= w_lo_sgn;
            r1_hi_scale  <= w_hi_scale;
            r1_lo_scale  <= w_lo_scale;
            r1_hi_frac   <= w_hi_frac;
            r1_lo_frac   <= w_lo_frac;
            r1_lo_zero   <= w_lo_zero;
            r1_both_zero <= w_a_zero & w_b_zero;
            r1_inf       <= in_a[1] | in_b[1];
            r2_valid     <= r1_valid;
            r2_sgn       <= r1_hi_sgn;
            r2_scale     <= r1_hi_scale;
            r2_sum       <= w_sum;
            r2_trunc     <= w_al_trunc;
            r2_inf       <= r1_inf;
            r2_both_zero <= r1_both_zero;
            r3_valid     <= r2_valid;
            r3_sum       <= w_res;
            r3_trunc     <= w_res_trunc;
            r4_valid     <= r3_valid;
            r4_sum       <= r3_sum;
            r4_trunc     <= r3_trunc;
        end
    end

`ifdef POSITADD_TAG_EN
    logic [TAG_W-1:0] r1_tag, r2_tag, r3_tag, r4_tag;

    // Tag travels beside its operands under the same advance and reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_tag <= {TAG_W{1'b0}}; r2_tag <= {TAG_W{1'b0}};
            r3_tag <= {TAG_W{1'b0}}; r4_tag <= {TAG_W{1'b0}};
        end else if (w_advance) begin
            r1_tag <= in_tag; r2_tag <= r1_tag; r3_tag <= r2_tag; r4_tag <= r3_tag;
        end
    end

    assign out_tag = r4_tag;
`else
    logic w_unused_tag;
    assign w_unused_tag = ^in_tag;
    assign out_tag      = {TAG_W{1'b0}};
`endif

endmodule

// File: tb/tb_positadd_raw_pipe.sv
// Scoreboard bench for positadd_raw_pipe: directed corner cases, a mid-stream stall,
// reset with ops in flight, and randomized traffic against an integer reference model.
module tb_positadd_raw_pipe;

    localparam int SW = 8;
    localparam int FW = 27;
    localparam int GW = 3;
    localparam int TW = 4;
    localparam int IW = SW + FW + 3;
    localparam int OW = SW + FW + GW + 4;
    localparam int FG = FW + GW;
`ifdef POSITADD_TAG_EN
    localparam bit TAG_ON = 1'b1;
`else
    localparam bit TAG_ON = 1'b0;
`endif

    typedef struct {
        logic [OW-1:0] sum;
        logic          trunc;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, in_sub, out_valid, out_ready, out_trunc;
    logic [IW-1:0] in_a, in_b;
    logic [TW-1:0] in_tag, out_tag, tag_cnt;
    logic [OW-1:0] out_sum;
    bit            rand_rdy = 1'b0;
    int            checks = 0;
    int            errors = 0;
    exp_t          q[$];

    positadd_raw_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_trunc(out_trunc), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic s, input int sc, input logic [FW-1:0] f,
                                         input logic inf, input logic zero);
        return {s, SW'(sc), f, inf, zero};
    endfunction

    function automatic logic [OW-1:0] mko(input logic s, input int sc, input longint f);
        return {s, (SW+1)'(sc), FG'(f), 2'b00};
    endfunction

    // Value model: mantissa integers with the hidden bit, aligned to the larger operand.
    function automatic exp_t ref_model(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic sub);
        exp_t   e;
        int     sa, sb, shi, k, d;
        longint fa, fb, fhi, flo, hiu, lofull, lou, s, fr;
        logic   ga, gb, ghi, glo, za, zb, tr;
        za = a[0]; zb = b[0];
        ga = a[IW-1]; gb = b[IW-1] ^ sub;
        sa = int'($signed(a[IW-2:FW+2])); sb = int'($signed(b[IW-2:FW+2]));
        fa = longint'(a[FW+1:2]); fb = longint'(b[FW+1:2]);
        if (za) begin ga = 1'b0; sa = 0; fa = 0; end
        if (zb) begin gb = 1'b0; sb = 0; fb = 0; end
        e.tag = TAG_ON ? tag_cnt : 4'd0;
        e.trunc = 1'b0;
        if (a[1] || b[1]) begin
            e.sum = {{(OW-2){1'b0}}, 2'b10};
        end else if (za && zb) begin
            e.sum = {{(OW-1){1'b0}}, 1'b1};
        end else if (za) begin
            e.sum = mko(gb, sb, fb <<< GW);
        end else if (zb) begin
            e.sum = mko(ga, sa, fa <<< GW);
        end else begin
            if ((sa > sb) || (sa == sb && fa >= fb)) begin
                ghi = ga; glo = gb; shi = sa; d = sa - sb; fhi = fa; flo = fb;
            end else begin
                ghi = gb; glo = ga; shi = sb; d = sb - sa; fhi = fb; flo = fa;
            end
            hiu    = ((64'sd1 <<< FW) + fhi) <<< GW;
            lofull = ((64'sd1 <<< FW) + flo) <<< GW;
            if (d > 40) begin
                lou = 0; tr = 1'b1;
            end else begin
                lou = lofull >>> d;
                tr  = ((lou <<< d) != lofull);
            end
            s = (ghi == glo) ? hiu + lou : hiu - lou;
            if (s == 0) begin
                e.sum = {{(OW-1){1'b0}}, 1'b1};
            end else begin
                k = 0;
                while ((s >>> (k + 1)) != 0) k++;
                if (k > FG) begin
                    tr = tr | (s[0] == 1'b1);
                    fr = (s >>> 1) - (64'sd1 <<< FG);
                end else begin
                    fr = (s <<< (FG - k)) - (64'sd1 <<< FG);
                end
                e.sum = mko(ghi, shi + k - FG, fr);
                e.trunc = tr;
            end
        end
        return e;
    endfunction

    // Called just after a negedge; returns just after the negedge following the transfer.
    task automatic send(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic sub,
                        input bit use_model, input logic [OW-1:0] esum, input logic etrunc);
        int   n;
        exp_t e;
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_tag = tag_cnt;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: actual in_ready=0 for %0d cycles, required 1", n);
        end else begin
            e = ref_model(a, b, sub);
            if (!use_model) begin e.sum = esum; e.trunc = etrunc; end
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tag_cnt  = tag_cnt + 4'd1;
    endtask

    task automatic rnd_pair(output logic [IW-1:0] a, output logic [IW-1:0] b, output logic sub);
        int sa, sb, r;
        sa = int'($urandom_range(0, 255)) - 128;
        sb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) - 128
                                         : sa + int'($urandom_range(0, 12)) - 6;
        if (sb > 127) sb = 127;
        if (sb < -128) sb = -128;
        a = {1'($urandom), SW'(sa), FW'($urandom), 2'b00};
        b = {1'($urandom), SW'(sb), FW'($urandom), 2'b00};
        r = int'($urandom_range(0, 15));
        if (r == 0) b = a;
        if (r == 1) a[0] = 1'b1;
        if (r == 2) b[0] = 1'b1;
        if (r == 3) b[1] = 1'b1;
        sub = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    // Monitor: compare every presented result with the queue head, pop on transfer.
    always @(negedge clk) begin
        #2;
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: actual sum %h with nothing pending, required no output", out_sum);
            end else begin
                chk("out_sum", 64'(out_sum), 64'(q[0].sum));
                chk("out_trunc", 64'(out_trunc), 64'(q[0].trunc));
                chk("out_tag", 64'(out_tag), 64'(q[0].tag));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] a, b;
        logic          sub;
        reset = 1'b1; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1; tag_cnt = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_sum", 64'(out_sum), 64'd0);
        chk("reset_out_trunc", 64'(out_trunc), 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        send(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), 1'b0, 1'b0, mko(0, 1, 0), 1'b0);
        send(mk(0, 0, 27'h4000000, 0, 0), mk(0, 0, 27'h4000000, 0, 0), 1'b1, 1'b0,
             {{(OW-1){1'b0}}, 1'b1}, 1'b0);
        send(mk(0, 0, 27'h4000000, 0, 0), mk(1, 0, 27'h4000000, 0, 0), 1'b0, 1'b0,
             {{(OW-1){1'b0}}, 1'b1}, 1'b0);
        send(mk(0, 0, 0, 0, 0), mk(0, -40, 0, 0, 0), 1'b0, 1'b0, mko(0, 0, 0), 1'b1);
        send(mk(0, 0, 0, 0, 0), mk(0, -3, 0, 0, 0), 1'b0, 1'b0,
             mko(0, 0, 64'sd1 <<< (FG - 3)), 1'b0);
        send(mk(0, 0, 0, 1, 0), mk(0, 0, 0, 0, 0), 1'b0, 1'b0, {{(OW-2){1'b0}}, 2'b10}, 1'b0);
        send(mk(0, 0, 0, 0, 1), mk(1, 1, 0, 0, 0), 1'b1, 1'b0, mko(0, 1, 0), 1'b0);
        drain();

        // Eight back-to-back ops with a three-cycle consumer stall once results appear.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    rnd_pair(a, b, sub);
                    send(a, b, sub, 1'b1, '0, 1'b0);
                end
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin @(negedge clk); n++; end
                chk("stall_first_valid", 64'(out_valid), 64'd1);
                @(negedge clk);
                out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    #1;
                    chk("stall_in_ready_low", 64'(in_ready), 64'd0);
                    chk("stall_out_valid_held", 64'(out_valid), 64'd1);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three ops in flight: none of them may come out.
        for (int i = 0; i < 3; i++) begin
            rnd_pair(a, b, sub);
            send(a, b, sub, 1'b1, '0, 1'b0);
        end
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("midreset_no_output", 64'(out_valid), 64'd0);
        end
        @(negedge clk);

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rnd_pair(a, b, sub);
            send(a, b, sub, 1'b1, '0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
